burst_mem_slave: RTL and testbench
==================================

BURST_MEM_SLAVE -- requirements
Module: burst_mem_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00000000, base byte address of the window.
REQ-002 Parameter MEM_WORDS, default 65536, depth in 32-bit words; SHALL be a power of two.
REQ-003 Parameter RD_LATENCY, default 2, cycles from beginTransaction to first read beat; legal range 1..15.
REQ-004 Parameter BUSY_PERIOD, default 4, busy-injection period; legal range 2..15; used only under REQ-030.
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 rst_ni  in  1  reset; synchronous, active-low.
REQ-007 bus_addrData_i  in  32  address on begin cycle; write data on data beats.
REQ-008 bus_byteEnables_i  in  4  write byte enables, sampled on begin cycle.
REQ-009 bus_burstSize_i  in  8  beats minus one, sampled on begin cycle.
REQ-010 bus_readNWrite_i  in  1  1 = read, 0 = write, sampled on begin cycle.
REQ-011 bus_beginTransaction_i / bus_endTransaction_i / bus_dataValid_i  in  1 each  master strobes.
REQ-012 bus_addrData_o  out  32  read data; 0 when no read beat is driven (wired-OR bus).
REQ-013 bus_endTransaction_o / bus_dataValid_o / bus_busy_o / bus_error_o  out  1 each  slave strobes; 0 when idle.

Function
REQ-014 States: IDLE, WAIT, RBURST, WBURST, DONE, ERR.
REQ-015 IDLE: on bus_beginTransaction_i, capture word address (bits[1:0] ignored), beats = burstSize+1, rnw, byte enables.
REQ-016 Hit check: burst hits only if BASE_ADDR <= addr and addr + 4*beats <= BASE_ADDR + 4*MEM_WORDS, computed 33-bit wide; a miss goes to ERR.
REQ-017 Read hit: WAIT for RD_LATENCY-1 cycles (0 cycles goes straight to RBURST), so the first beat appears RD_LATENCY cycles after the begin cycle.
REQ-018 RBURST: one beat per non-busy cycle; bus_dataValid_o = 1; bus_addrData_o = mem[index]; index += 1 per beat; exactly `beats` beats.
REQ-019 After the last read beat: DONE, bus_endTransaction_o = 1 for one cycle, then IDLE.
REQ-020 Write hit: WBURST; each cycle with bus_dataValid_i = 1 and bus_busy_o = 0 writes enabled bytes of bus_addrData_i to mem[index], then index += 1.
REQ-021 WBURST: data beats beyond `beats` are ignored.
REQ-022 WBURST: bus_endTransaction_i returns to IDLE next cycle; the slave emits no end pulse on writes.
REQ-023 ERR: bus_error_o = 1 and bus_endTransaction_o = 1 together for one cycle, then IDLE; memory untouched.
REQ-024 bus_endTransaction_i in WAIT/RBURST aborts: IDLE next cycle, no further beats, no end pulse.
REQ-025 bus_beginTransaction_i outside IDLE is ignored.
REQ-026 burstSize 0 gives a single-beat transfer; 255 gives 256 beats.
REQ-027 bus_dataValid_i and bus_endTransaction_i in the same cycle: the beat is written, then IDLE.

Reset
REQ-028 rst_ni = 0 at a clock edge forces IDLE, all outputs 0 and counters 0, including mid-burst; the pending transfer is dropped.
REQ-029 Memory contents are not cleared by reset.

Configuration
REQ-030 MEMSLAVE_BUSY_INJECT_EN defined:
- a counter cleared on entering RBURST/WBURST drives bus_busy_o = 1 every BUSY_PERIOD-th cycle (count == BUSY_PERIOD-1, then clears);
- no read beat is driven and no write beat is accepted in a busy cycle;
- beat count, order and data are unchanged.
REQ-031 MEMSLAVE_BUSY_INJECT_EN undefined: bus_busy_o is constant 0; no counter logic is present.

Verification
REQ-032 Preload mem[0..3] = 11,22,33,44; read addr 0x0, burstSize 3 -> dataValid on cycles +2..+5 with 11,22,33,44; end pulse on +6.
REQ-033 Write addr 0x8, byteEnables 4'b0011, data 0xAABBCCDD over old 0x12345678 -> readback 0x1234CCDD.
REQ-034 MEM_WORDS = 256, read addr 0x3FC, burstSize 1 -> error and end pulses in the same cycle; no dataValid; memory unchanged.
REQ-035 Read burstSize 7 with endTransaction_i after the 3rd beat -> exactly 3 beats, no end pulse; next begin is accepted normally.
REQ-036 rst_ni low during beat 2 of an 8-beat read -> all outputs 0 next cycle; the following single read returns correct data.
REQ-037 MEMSLAVE_BUSY_INJECT_EN, BUSY_PERIOD 4, 8-beat read -> busy on every 4th burst cycle; 8 beats total in order.

Source files
------------

// File: rtl/burst_mem_slave_if.sv
// Burst memory bus: master strobes/address/data in, slave strobes/read data out.
interface burst_mem_slave_if;
  logic [31:0] bus_addrData_i;
  logic [3:0]  bus_byteEnables_i;
  logic [7:0]  bus_burstSize_i;
  logic        bus_readNWrite_i;
  logic        bus_beginTransaction_i;
  logic        bus_endTransaction_i;
  logic        bus_dataValid_i;
  logic [31:0] bus_addrData_o;
  logic        bus_endTransaction_o;
  logic        bus_dataValid_o;
  logic        bus_busy_o;
  logic        bus_error_o;

  modport master (
    output bus_addrData_i, bus_byteEnables_i, bus_burstSize_i,
    output bus_readNWrite_i, bus_beginTransaction_i,
    output bus_endTransaction_i, bus_dataValid_i,
    input  bus_addrData_o, bus_endTransaction_o,
    input  bus_dataValid_o, bus_busy_o, bus_error_o
  );

  modport slave (
    input  bus_addrData_i, bus_byteEnables_i, bus_burstSize_i,
    input  bus_readNWrite_i, bus_beginTransaction_i,
    input  bus_endTransaction_i, bus_dataValid_i,
    output bus_addrData_o, bus_endTransaction_o,
    output bus_dataValid_o, bus_busy_o, bus_error_o
  );
endinterface

// File: rtl/burst_mem_slave.sv
// Burst-capable memory slave with address window check.
// Optional busy-cycle injection under MEMSLAVE_BUSY_INJECT_EN.
module burst_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 65536,
  parameter int          RD_LATENCY  = 2,
  parameter int          BUSY_PERIOD = 4
) (
  input logic           clk_i,
  input logic           rst_ni,
  burst_mem_slave_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, WAIT, RBURST, WBURST, DONE, ERR
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [8:0]    left, left_n;
  logic [3:0]    wcnt, wcnt_n;
  logic [3:0]    be, be_n;
  logic          busy;
  logic          we;
  logic          dv;
  logic          end_o;
  logic          err;
  logic [31:0]   rdata;

  logic [31:0] mem [MEM_WORDS];

  // 33-bit window check so a burst running past 4 GiB cannot wrap into a hit
  logic [8:0]  beats;
  logic [32:0] a33, end33, lo33, hi33, off33;
  logic        hit;
  logic [AW-1:0] start;

  assign beats = {1'b0, bus.bus_burstSize_i} + 9'd1;
  assign a33   = {1'b0, bus.bus_addrData_i & ~32'h3};
  assign end33 = a33 + {22'b0, beats, 2'b00};
  assign lo33  = {1'b0, BASE_ADDR};
  assign hi33  = lo33 + (33'(MEM_WORDS) << 2);
  assign off33 = a33 - lo33;
  assign hit   = (a33 >= lo33) && (end33 <= hi33);
  assign start = AW'(off33 >> 2);

  always_comb rdata = mem[idx];

  wire in_burst = (state == RBURST) || (state == WBURST);

`ifdef MEMSLAVE_BUSY_INJECT_EN
  logic [3:0] bcnt, bcnt_n;

  assign busy = in_burst && (bcnt == 4'(BUSY_PERIOD - 1));

  always_comb begin
    bcnt_n = bcnt;
    if (in_burst)
      bcnt_n = busy ? 4'd0 : bcnt + 4'd1;
    if (!in_burst)
      bcnt_n = 4'd0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) bcnt <= 4'd0;
    else         bcnt <= bcnt_n;
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    left_n  = left;
    wcnt_n  = wcnt;
    be_n    = be;
    we      = 1'b0;
    dv      = 1'b0;
    end_o   = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.bus_beginTransaction_i) begin
          idx_n  = start;
          left_n = beats;
          be_n   = bus.bus_byteEnables_i;
          if (!hit)
            state_n = ERR;
          else if (!bus.bus_readNWrite_i)
            state_n = WBURST;
          else if (RD_LATENCY > 1) begin
            state_n = WAIT;
            wcnt_n  = 4'(RD_LATENCY - 2);
          end else
            state_n = RBURST;
        end
      end
      WAIT: begin
        if (bus.bus_endTransaction_i)
          state_n = IDLE;
        else if (wcnt == 4'd0)
          state_n = RBURST;
        else
          wcnt_n = wcnt - 4'd1;
      end
      RBURST: begin
        if (bus.bus_endTransaction_i)
          state_n = IDLE;
        else if (!busy) begin
          dv     = 1'b1;
          idx_n  = idx + 1'b1;
          left_n = left - 9'd1;
          if (left == 9'd1)
            state_n = DONE;
        end
      end
      WBURST: begin
        if (bus.bus_dataValid_i && !busy && left != 9'd0) begin
          we     = 1'b1;
          idx_n  = idx + 1'b1;
          left_n = left - 9'd1;
        end
        if (bus.bus_endTransaction_i)
          state_n = IDLE;
      end
      DONE: begin
        end_o   = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        end_o   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      idx   <= '0;
      left  <= '0;
      wcnt  <= '0;
      be    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      left  <= left_n;
      wcnt  <= wcnt_n;
      be    <= be_n;
    end
  end

  // Contents survive reset
  always_ff @(posedge clk_i) begin
    if (rst_ni && we)
      for (int b = 0; b < 4; b++)
        if (be[b])
          mem[idx][8*b +: 8] <= bus.bus_addrData_i[8*b +: 8];
  end

  assign bus.bus_addrData_o       = dv ? rdata : 32'h0;
  assign bus.bus_dataValid_o      = dv;
  assign bus.bus_endTransaction_o = end_o;
  assign bus.bus_error_o          = err;
  assign bus.bus_busy_o           = busy;

endmodule

// File: tb/tb_burst_mem_slave.sv
// Directed bench for burst_mem_slave (MEM_WORDS=256 window).
// Expected timings adjust when MEMSLAVE_BUSY_INJECT_EN is defined.
module tb_burst_mem_slave;

`ifdef MEMSLAVE_BUSY_INJECT_EN
  localparam int BZ = 1;
`else
  localparam int BZ = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  burst_mem_slave_if bus();

  burst_mem_slave #(
    .BASE_ADDR  (32'h0),
    .MEM_WORDS  (256),
    .RD_LATENCY (2),
    .BUSY_PERIOD(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic [31:0] rdata [0:299];
  logic [31:0] wdata [0:15];
  int nbeats, first, endc, errc, busyn;

  task automatic idle();
    bus.bus_addrData_i         = '0;
    bus.bus_byteEnables_i      = '0;
    bus.bus_burstSize_i        = '0;
    bus.bus_readNWrite_i       = 1'b0;
    bus.bus_beginTransaction_i = 1'b0;
    bus.bus_endTransaction_i   = 1'b0;
    bus.bus_dataValid_i        = 1'b0;
  endtask

  task automatic start(input logic [31:0] a, input logic [3:0] be,
                       input logic [7:0] bs, input logic rnw);
    @(posedge clk); #1;
    bus.bus_beginTransaction_i = 1'b1;
    bus.bus_addrData_i         = a;
    bus.bus_byteEnables_i      = be;
    bus.bus_burstSize_i        = bs;
    bus.bus_readNWrite_i       = rnw;
    @(posedge clk); #1;
    idle();
  endtask

  // Cycle 0 is the begin cycle; samples land on later cycles.
  task automatic do_read(input logic [31:0] a, input logic [7:0] bs,
                         input int abort_after, input int max_cyc);
    bit aborted = 0;
    nbeats = 0; first = -1; endc = -1; errc = -1; busyn = 0;
    start(a, 4'h0, bs, 1'b1);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (bus.bus_dataValid_o) begin
        if (nbeats < 300) rdata[nbeats] = bus.bus_addrData_o;
        if (first < 0) first = c;
        nbeats++;
      end
      if (bus.bus_endTransaction_o) endc = c;
      if (bus.bus_error_o) errc = c;
      if (bus.bus_busy_o) busyn++;
      @(posedge clk); #1;
      bus.bus_endTransaction_i = 1'b0;
      if (abort_after > 0 && nbeats == abort_after && !aborted) begin
        bus.bus_endTransaction_i = 1'b1;
        aborted = 1;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be,
                          input logic [7:0] bs, input int n,
                          input bit end_last);
    int i = 0;
    int guard = 0;
    bit acc;
    start(a, be, bs, 1'b0);
    while (i < n) begin
      bus.bus_dataValid_i      = 1'b1;
      bus.bus_addrData_i       = wdata[i];
      bus.bus_endTransaction_i = end_last && (i == n - 1);
      @(negedge clk);
      acc = !bus.bus_busy_o;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
      if (guard > 200) begin
        chk("wr_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    idle();
    if (!end_last) begin
      bus.bus_endTransaction_i = 1'b1;
      @(posedge clk); #1;
      bus.bus_endTransaction_i = 1'b0;
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", bus.bus_addrData_o, 32'h0);
    chk("rst_strobes", {28'b0, bus.bus_dataValid_o, bus.bus_endTransaction_o,
                        bus.bus_busy_o, bus.bus_error_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Byte-enable merge, with dataValid and end in the same cycle
    wdata[0] = 32'h1234_5678;
    do_write(32'h8, 4'hF, 8'd0, 1, 1'b1);
    wdata[0] = 32'hAABB_CCDD;
    do_write(32'h8, 4'b0011, 8'd0, 1, 1'b0);
    do_read(32'h8, 8'd0, 0, 6);
    chk("partial_wr", rdata[0], 32'h1234_CCDD);
    chk("partial_nb", 32'(nbeats), 32'd1);

    // Four-beat read with timing
    wdata[0] = 32'd11; wdata[1] = 32'd22; wdata[2] = 32'd33; wdata[3] = 32'd44;
    do_write(32'h0, 4'hF, 8'd3, 4, 1'b0);
    do_read(32'h0, 8'd3, 0, 12);
    chk("rd4_nbeats", 32'(nbeats), 32'd4);
    chk("rd4_first", 32'(first), 32'd2);
    for (int k = 0; k < 4; k++)
      chk("rd4_data", rdata[k], 32'(11 * (k + 1)));
    chk("rd4_end", 32'(endc), 32'(6 + BZ));
    chk("rd4_noerr", 32'(errc), 32'hFFFF_FFFF);

    // Window edge: last word hits, one past it misses
    wdata[0] = 32'hCAFE_F00D;
    do_write(32'h3FC, 4'hF, 8'd0, 1, 1'b0);
    do_read(32'h3FC, 8'd1, 0, 6);
    chk("miss_err", 32'(errc), 32'd1);
    chk("miss_end", 32'(endc), 32'd1);
    chk("miss_nb", 32'(nbeats), 32'd0);
    wdata[0] = 32'hDEAD_BEEF; wdata[1] = 32'hDEAD_BEEF;
    do_write(32'h3FC, 4'hF, 8'd1, 2, 1'b0);
    do_read(32'h3FC, 8'd0, 0, 6);
    chk("miss_memkeep", rdata[0], 32'hCAFE_F00D);
    chk("edge_noerr", 32'(errc), 32'hFFFF_FFFF);
    do_read(32'h400, 8'd0, 0, 4);
    chk("oob_err", 32'(errc), 32'd1);

    // Surplus write beats are dropped
    wdata[0] = 32'hA1; wdata[1] = 32'hB2;
    do_write(32'h40, 4'hF, 8'd1, 2, 1'b0);
    wdata[0] = 32'hC3; wdata[1] = 32'hD4;
    do_write(32'h40, 4'hF, 8'd0, 2, 1'b0);
    do_read(32'h40, 8'd1, 0, 8);
    chk("extra_w0", rdata[0], 32'hC3);
    chk("extra_w1", rdata[1], 32'hB2);

    // Abort after 3 beats
    for (int k = 0; k < 8; k++) wdata[k] = 32'h100 + 32'(k);
    do_write(32'h20, 4'hF, 8'd7, 8, 1'b0);
    do_read(32'h20, 8'd7, 3, 16);
    chk("abort_nb", 32'(nbeats), 32'd3);
    chk("abort_noend", 32'(endc), 32'hFFFF_FFFF);
    chk("abort_d2", rdata[2], 32'h102);
    do_read(32'h24, 8'd0, 0, 6);
    chk("post_abort_d", rdata[0], 32'h101);
    chk("post_abort_end", 32'(endc), 32'd3);

    // Reset during the second beat of an 8-beat read
    start(32'h20, 4'h0, 8'd7, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_beat2", bus.bus_addrData_o, 32'h101);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_data", bus.bus_addrData_o, 32'h0);
    chk("rstmid_strobes", {28'b0, bus.bus_dataValid_o, bus.bus_endTransaction_o,
                           bus.bus_busy_o, bus.bus_error_o}, 32'h0);
    do_read(32'h28, 8'd0, 0, 6);
    chk("rstmid_after", rdata[0], 32'h102);

    // Full 8-beat read, busy pattern
    do_read(32'h20, 8'd7, 0, 16);
    chk("rd8_nb", 32'(nbeats), 32'd8);
    for (int k = 0; k < 8; k++)
      chk("rd8_data", rdata[k], 32'h100 + 32'(k));
    chk("rd8_end", 32'(endc), 32'(10 + 2 * BZ));
    chk("rd8_busy", 32'(busyn), 32'(2 * BZ));

    // Largest burst covers the whole window
    do_read(32'h0, 8'd255, 0, 360);
    chk("rd256_nb", 32'(nbeats), 32'd256);
    chk("rd256_d0", rdata[0], 32'd11);
    chk("rd256_dlast", rdata[255], 32'hCAFE_F00D);
    chk("rd256_end", 32'(endc), BZ ? 32'd343 : 32'd258);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
